// File: rtl/hand_if.sv
// Controller <-> hand datapath bus: card value, slot load strobes, and the
// score / pcard3 / seven-segment / load-error results coming back.
interface hand_if;
    logic [3:0] new_card;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic       load_err;

    // Round controller / card source side.
    modport master (
        output new_card,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  pcard3, pscore, dscore,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
        input  load_err
    );

    // Datapath side.
    modport slave (
        input  new_card,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output pcard3, pscore, dscore,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
        output load_err
    );
endinterface

// File: rtl/hand_datapath.sv
// Baccarat hand datapath: six card slots (player 1-3, dealer 1-3) loaded from
// new_card on controller strobes, combinational mod-10 hand scores, pcard3
// export and per-slot seven-segment decode.
// Optional: define HAND_DATAPATH_LOAD_CHECK_EN to build the sticky load_err
// protocol checker (multi-strobe, reload of occupied slot, invalid card).

// One card slot: register plus its seven-segment decode.
module hand_slot #(
    parameter logic [6:0] BLANK_SEG = 7'b1111111
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load,
    input  logic [3:0] new_card,
    output logic [3:0] value,
    output logic [6:0] seg
);
    // Slot register: reset wins over load; otherwise hold.
    always_ff @(posedge slow_clock) begin
        if (!resetb)
            value <= 4'd0;
        else if (load)
            value <= new_card;
    end

    // Active-low {g,f,e,d,c,b,a} glyph for the held card; empty/invalid blank.
    always_comb begin
        seg = BLANK_SEG;
        case (value)
            4'd1:    seg = 7'b0001000; // A
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            4'd10:   seg = 7'b1000000; // shown as 0
            4'd11:   seg = 7'b1100001; // J
            4'd12:   seg = 7'b0011000; // q
            4'd13:   seg = 7'b0001001; // H (king)
            default: seg = BLANK_SEG;
        endcase
    end
endmodule

module hand_datapath #(
    parameter logic [6:0] BLANK_SEG = 7'b1111111
) (
    input  logic   slow_clock,
    input  logic   resetb,
    hand_if.slave  bus
);
    localparam int NUM_SLOTS = 6;

    // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3.
    logic [NUM_SLOTS-1:0]      load_vec;
    logic [NUM_SLOTS-1:0][3:0] slot_val;
    logic [NUM_SLOTS-1:0][6:0] slot_seg;

    assign load_vec = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                       bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        hand_slot #(.BLANK_SEG(BLANK_SEG)) u_slot (
            .slow_clock (slow_clock),
            .resetb     (resetb),
            .load       (load_vec[i]),
            .new_card   (bus.new_card),
            .value      (slot_val[i]),
            .seg        (slot_seg[i])
        );
    end

    // Baccarat point value: 1-9 count face value, tens/faces/invalid count 0.
    function automatic logic [3:0] card_pts(input logic [3:0] v);
        return (v >= 4'd1 && v <= 4'd9) ? v : 4'd0;
    endfunction

    // Three-card sum (max 27) folded to 0-9 by a single conditional subtract.
    function automatic logic [3:0] hand_score(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, card_pts(a)} + {1'b0, card_pts(b)} + {1'b0, card_pts(c)};
        if (s >= 5'd20)
            s = s - 5'd20;
        else if (s >= 5'd10)
            s = s - 5'd10;
        return s[3:0];
    endfunction

    // Scores, pcard3 and displays come straight off the slot registers.
    always_comb begin
        bus.pscore = hand_score(slot_val[0], slot_val[1], slot_val[2]);
        bus.dscore = hand_score(slot_val[3], slot_val[4], slot_val[5]);
        bus.pcard3 = slot_val[2];
        bus.HEX0   = slot_seg[0];
        bus.HEX1   = slot_seg[1];
        bus.HEX2   = slot_seg[2];
        bus.HEX3   = slot_seg[3];
        bus.HEX4   = slot_seg[4];
        bus.HEX5   = slot_seg[5];
    end

`ifdef HAND_DATAPATH_LOAD_CHECK_EN
    logic [NUM_SLOTS-1:0] occupied;
    logic                 load_err_q;
    logic                 multi_hit, occ_hit, bad_card;

    // Protocol violations seen on this cycle's strobes.
    always_comb begin
        // x & (x-1) is nonzero exactly when two or more bits are set.
        multi_hit = |(load_vec & (load_vec - 6'd1));
        occ_hit   = |(load_vec & occupied);
        bad_card  = (|load_vec) &&
                    (bus.new_card == 4'd0 || bus.new_card >= 4'd14);
    end

    // Occupancy tracking and sticky error flag; loads proceed regardless.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            occupied   <= '0;
            load_err_q <= 1'b0;
        end else begin
            occupied <= occupied | load_vec;
            if (multi_hit || occ_hit || bad_card)
                load_err_q <= 1'b1;
        end
    end

    assign bus.load_err = load_err_q;
`else
    assign bus.load_err = 1'b0;
`endif

endmodule

// File: tb/tb_hand_datapath.sv
// Directed bench for hand_datapath: a card-level model (slot array, point
// sums mod 10, glyph table, error rules) is checked against the DUT on every
// falling edge, plus literal expectations at the key points of each scenario.
module tb_hand_datapath;
    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;
    hand_if bus ();

    hand_datapath dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef HAND_DATAPATH_LOAD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Model state: card value per slot, occupancy, sticky error.
    int mdl_card [6];
    bit mdl_occ  [6];
    bit mdl_err;

    function automatic int pts(input int v);
        return (v >= 1 && v <= 9) ? v : 0;
    endfunction

    function automatic logic [6:0] glyph(input int v);
        case (v)
            1: return 7'b0001000;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;
            5: return 7'b0010010;   6: return 7'b0000010;
            7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b1000000;
           11: return 7'b1100001;  12: return 7'b0011000;
           13: return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int mdl_score(input int base);
        return (pts(mdl_card[base]) + pts(mdl_card[base+1]) + pts(mdl_card[base+2])) % 10;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge slow_clock) begin
        if (chk_en) begin
            chk("pscore", int'(bus.pscore), mdl_score(0));
            chk("dscore", int'(bus.dscore), mdl_score(3));
            chk("pcard3", int'(bus.pcard3), mdl_card[2]);
            chk("HEX0", int'(bus.HEX0), int'(glyph(mdl_card[0])));
            chk("HEX1", int'(bus.HEX1), int'(glyph(mdl_card[1])));
            chk("HEX2", int'(bus.HEX2), int'(glyph(mdl_card[2])));
            chk("HEX3", int'(bus.HEX3), int'(glyph(mdl_card[3])));
            chk("HEX4", int'(bus.HEX4), int'(glyph(mdl_card[4])));
            chk("HEX5", int'(bus.HEX5), int'(glyph(mdl_card[5])));
            chk("load_err", int'(bus.load_err), int'(mdl_err));
        end
    end

    // One clock: apply inputs (away from the rising edge), advance the model
    // at the edge, return at the following falling edge once checks have run.
    // ld bits: 0 p1, 1 p2, 2 p3, 3 d1, 4 d2, 5 d3.
    task automatic step(input bit rst, input logic [5:0] ld, input int card);
        int nld;
        resetb          = ~rst;
        bus.new_card    = 4'(card);
        bus.load_pcard1 = ld[0]; bus.load_pcard2 = ld[1]; bus.load_pcard3 = ld[2];
        bus.load_dcard1 = ld[3]; bus.load_dcard2 = ld[4]; bus.load_dcard3 = ld[5];
        @(posedge slow_clock);
        if (rst) begin
            foreach (mdl_card[i]) begin mdl_card[i] = 0; mdl_occ[i] = 1'b0; end
            mdl_err = 1'b0;
        end else begin
            nld = $countones(ld);
            if (CHECK_EN) begin
                if (nld > 1) mdl_err = 1'b1;
                if (nld > 0 && (card == 0 || card >= 14)) mdl_err = 1'b1;
                for (int i = 0; i < 6; i++)
                    if (ld[i] && mdl_occ[i]) mdl_err = 1'b1;
            end
            for (int i = 0; i < 6; i++)
                if (ld[i]) begin mdl_card[i] = card; mdl_occ[i] = 1'b1; end
        end
        @(negedge slow_clock);
    endtask

    task automatic load(input int slot, input int card);
        logic [5:0] ld;
        ld = 6'b0;
        ld[slot] = 1'b1;
        step(1'b0, ld, card);
    endtask

    initial begin
        foreach (mdl_card[i]) begin mdl_card[i] = 0; mdl_occ[i] = 1'b0; end
        mdl_err = 1'b0;
        bus.new_card = 4'd0;
        bus.load_pcard1 = 0; bus.load_pcard2 = 0; bus.load_pcard3 = 0;
        bus.load_dcard1 = 0; bus.load_dcard2 = 0; bus.load_dcard3 = 0;

        // Reset with a competing load: reset must win.
        step(1'b1, 6'b000001, 5);
        chk_en = 1'b1;
        chk("rst_pscore", int'(bus.pscore), 0);
        chk("rst_dscore", int'(bus.dscore), 0);
        chk("rst_pcard3", int'(bus.pcard3), 0);
        chk("rst_HEX0", int'(bus.HEX0), 7'b1111111);
        chk("rst_HEX5", int'(bus.HEX5), 7'b1111111);
        chk("rst_err", int'(bus.load_err), 0);
        step(1'b0, 6'b0, 9);   // idle cycle: nothing moves

        // Player two-card wrap: 7+8 = 15 -> 5.
        load(0, 7);
        load(1, 8);
        chk("wrap_pscore", int'(bus.pscore), 5);
        chk("wrap_HEX0", int'(bus.HEX0), 7'b1111000);
        chk("wrap_HEX1", int'(bus.HEX1), 7'b0000000);

        // Dealer K, Q, 9 -> 9; then player 10, A, 4 -> 5 (reloads p1/p2).
        step(1'b1, 6'b0, 0);
        load(3, 13); load(4, 12); load(5, 9);
        chk("face_dscore", int'(bus.dscore), 9);
        chk("face_HEX5", int'(bus.HEX5), 7'b0010000);
        chk("face_HEX3", int'(bus.HEX3), 7'b0001001);
        load(0, 10); load(1, 1); load(2, 4);
        chk("p3_pscore", int'(bus.pscore), 5);
        chk("p3_pcard3", int'(bus.pcard3), 4);
        chk("p3_HEX2", int'(bus.HEX2), 7'b0011001);
        chk("p3_HEX0", int'(bus.HEX0), 7'b1000000);

        // Max sum 27 -> 7; reset then 6+4 -> 0.
        step(1'b1, 6'b0, 0);
        load(0, 9); load(1, 9); load(2, 9);
        chk("max_pscore", int'(bus.pscore), 7);
        step(1'b1, 6'b0, 0);
        load(0, 6); load(1, 4);
        chk("ten_pscore", int'(bus.pscore), 0);

        // Reload occupied slot: value updates, error per build option.
        step(1'b1, 6'b0, 0);
        load(0, 3);
        chk("clean_err", int'(bus.load_err), 0);
        load(0, 6);
        chk("reload_HEX0", int'(bus.HEX0), 7'b0000010);
        chk("reload_err", int'(bus.load_err), int'(CHECK_EN));
        load(1, 2);
        chk("sticky_err", int'(bus.load_err), int'(CHECK_EN));
        step(1'b1, 6'b0, 0);
        chk("clr_err", int'(bus.load_err), 0);

        // Multi-strobe: both slots take the same card.
        step(1'b0, 6'b010010, 3);
        chk("multi_pscore", int'(bus.pscore), 3);
        chk("multi_dscore", int'(bus.dscore), 3);
        chk("multi_err", int'(bus.load_err), int'(CHECK_EN));

        // Invalid cards: blank glyph, zero points, error per build option.
        step(1'b1, 6'b0, 0);
        load(0, 14);
        chk("inv_HEX0", int'(bus.HEX0), 7'b1111111);
        chk("inv_err", int'(bus.load_err), int'(CHECK_EN));
        step(1'b1, 6'b0, 0);
        load(3, 0);
        chk("zero_err", int'(bus.load_err), int'(CHECK_EN));
        load(4, 15); load(5, 11); load(2, 5);
        chk("inv_dscore", int'(bus.dscore), 0);
        chk("inv_HEX4", int'(bus.HEX4), 7'b1111111);
        chk("jack_HEX5", int'(bus.HEX5), 7'b1100001);
        chk("p3only_pscore", int'(bus.pscore), 5);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
